// File: rtl/bnn_input_loader.sv
// bnn_input_loader: deserialises a binary image and filter bank from a byte stream for layer_one
module bnn_input_loader #(
  parameter int         IMG_DIM    = 28,
  parameter int         N_FILT     = 8,
  parameter int         K          = 3,
  parameter logic [2:0] LOAD_STATE = 3'd1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [2:0]                             state,
  input  logic [7:0]                             data_in,
  input  logic                                   data_valid,
  output logic                                   ready,
  output logic [IMG_DIM-1:0][IMG_DIM-1:0]        pixels,
  output logic [N_FILT-1:0][K-1:0][K-1:0]        weights,
  output logic                                   load_done
);
  localparam int PIX_BITS  = IMG_DIM * IMG_DIM;
  localparam int PIX_BYTES = (PIX_BITS + 7) / 8;
  localparam int WGT_BITS  = N_FILT * K * K;
  localparam int WGT_BYTES = (WGT_BITS + 7) / 8;
  localparam int PW        = PIX_BYTES * 8;
  localparam int WW        = WGT_BYTES * 8;

  typedef enum logic [1:0] {IDLE, LOAD_PIX, LOAD_WGT, DONE} fsm_t;

  fsm_t                fsm_q, fsm_d;
  logic [6:0]          byte_cnt_q, byte_cnt_d;
  logic [PIX_BITS-1:0] pix_q, pix_d;
  logic [WGT_BITS-1:0] wgt_q, wgt_d;
  logic                en, acc, last;
  logic [PW-1:0]       pmask, pdata;
  logic [WW-1:0]       wmask, wdata;

  assign en   = state == LOAD_STATE;
  assign acc  = data_valid && ready;
  assign last = byte_cnt_q == 7'(fsm_q == LOAD_PIX ? PIX_BYTES - 1 : WGT_BYTES - 1);

  // Packed row-major / filter-major layout makes the linear stream index the flat bit index
  assign pmask = PW'(8'hFF) << {byte_cnt_q, 3'b000};
  assign pdata = PW'(data_in) << {byte_cnt_q, 3'b000};
  assign wmask = WW'(8'hFF) << {byte_cnt_q, 3'b000};
  assign wdata = WW'(data_in) << {byte_cnt_q, 3'b000};
  assign pix_d = acc && fsm_q == LOAD_PIX
               ? (pix_q & ~pmask[PIX_BITS-1:0]) | (pdata[PIX_BITS-1:0] & pmask[PIX_BITS-1:0])
               : pix_q;
  assign wgt_d = acc && fsm_q == LOAD_WGT
               ? (wgt_q & ~wmask[WGT_BITS-1:0]) | (wdata[WGT_BITS-1:0] & wmask[WGT_BITS-1:0])
               : wgt_q;
  assign pixels  = pix_q;
  assign weights = wgt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= IDLE;
      byte_cnt_q <= '0;
      pix_q      <= '0;
      wgt_q      <= '0;
    end else begin
      fsm_q      <= fsm_d;
      byte_cnt_q <= byte_cnt_d;
      pix_q      <= pix_d;
      wgt_q      <= wgt_d;
    end
  end

  always_comb begin
    fsm_d      = fsm_q;
    byte_cnt_d = byte_cnt_q;
    case (fsm_q)
      IDLE: if (en) begin
        fsm_d      = LOAD_PIX;
        byte_cnt_d = '0;
      end
      LOAD_PIX, LOAD_WGT: if (!en) begin
        fsm_d      = IDLE;
        byte_cnt_d = '0;
      end else if (acc) begin
        fsm_d      = last ? (fsm_q == LOAD_PIX ? LOAD_WGT : DONE) : fsm_q;
        byte_cnt_d = last ? '0 : byte_cnt_q + 7'd1;
      end
      default: if (!en) fsm_d = IDLE;
    endcase
  end

  always_comb begin
    ready     = en && (fsm_q == LOAD_PIX || fsm_q == LOAD_WGT);
    load_done = fsm_q == DONE;
  end
endmodule

// File: tb/tb_bnn_input_loader.sv
// tb_bnn_input_loader: table, directed and randomized checks of bnn_input_loader against a stream model
module tb_bnn_input_loader;
  logic                  clk = 0, rst = 0;
  logic [2:0]            state = 0;
  logic [7:0]            data_in = 0;
  logic                  data_valid = 0;
  logic                  ready, load_done;
  logic [27:0][27:0]     pixels;
  logic [7:0][2:0][2:0]  weights;

  bnn_input_loader dut (
    .clk(clk), .rst(rst), .state(state), .data_in(data_in), .data_valid(data_valid),
    .ready(ready), .pixels(pixels), .weights(weights), .load_done(load_done)
  );

  always #5 clk = ~clk;

  int         total = 0, bad = 0;
  bit         mp[28][28];
  bit         mw[8][3][3];
  int         mphase = 0, mcnt = 0;
  logic [7:0] stream[107];

  typedef struct {
    logic [7:0] pf, wf;
    int pr, pc; bit pe;
    int f, wr, wc; bit we;
  } vec_t;

  task automatic chk(string name, logic [783:0] act, logic [783:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic mclear();
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) mp[r][c] = 0;
    for (int f = 0; f < 8; f++) for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) mw[f][r][c] = 0;
  endtask

  task automatic model_write(int k, logic [7:0] d);
    for (int b = 0; b < 8; b++) begin
      if (k < 98) begin
        int i = 8 * k + b;
        if (i < 784) mp[i / 28][i % 28] = d[b];
      end else begin
        int j = 8 * (k - 98) + b;
        if (j < 72) mw[j / 9][(j % 9) / 3][j % 3] = d[b];
      end
    end
  endtask

  task automatic chk_arrays(string tag);
    logic [27:0][27:0]    ep;
    logic [7:0][2:0][2:0] ew;
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) ep[r][c] = mp[r][c];
    for (int f = 0; f < 8; f++) for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) ew[f][r][c] = mw[f][r][c];
    chk({tag, "_pix"}, pixels, ep);
    chk({tag, "_wgt"}, weights, ew);
  endtask

  // One clock: check handshake outputs, apply acceptance to the model, advance the model phase
  task automatic tick();
    bit er;
    #1;
    er = mphase == 1 && state == 3'd1 && !rst;
    chk("ready", ready, er);
    chk("load_done", load_done, mphase == 2);
    if (er && data_valid) begin
      model_write(mcnt, data_in);
      mcnt++;
    end
    @(posedge clk);
    if (rst || state != 3'd1) mphase = 0;
    else if (mphase == 0) begin mphase = 1; mcnt = 0; end
    else if (mphase == 1 && mcnt == 107) mphase = 2;
    #1;
  endtask

  task automatic send_bytes(int from, int to, int gap);
    for (int n = from; n < to; n++) begin
      repeat ($urandom_range(0, gap)) begin data_valid = 0; tick(); end
      data_in = stream[n];
      data_valid = 1;
      tick();
    end
    data_valid = 0;
  endtask

  task automatic enter();
    state = 3'd1;
    data_valid = 1;
    data_in = 8'($urandom);
    tick();
  endtask

  task automatic load(int gap);
    enter();
    send_bytes(0, 107, gap);
    chk("done_latency", load_done, 1'b1);
  endtask

  task automatic junk_ticks(int n);
    repeat (n) begin data_valid = 1; data_in = 8'($urandom); tick(); end
    data_valid = 0;
  endtask

  task automatic fill(logic [7:0] pf, logic [7:0] wf);
    for (int n = 0; n < 107; n++) stream[n] = n < 98 ? pf : wf;
  endtask

  task automatic rand_stream();
    for (int n = 0; n < 107; n++) stream[n] = 8'($urandom);
  endtask

  initial begin
    vec_t tbl[4];
    tbl[0] = '{8'hAA, 8'hFF, 0, 1, 1'b1, 7, 2, 2, 1'b1};
    tbl[1] = '{8'hAA, 8'hFF, 1, 0, 1'b0, 0, 0, 0, 1'b1};
    tbl[2] = '{8'h55, 8'h0F, 0, 0, 1'b1, 0, 1, 1, 1'b0};
    tbl[3] = '{8'h55, 8'h0F, 27, 27, 1'b0, 0, 0, 0, 1'b1};
    mclear();
    #1 rst = 1; data_valid = 1; data_in = 8'hFF;
    #1;
    chk("rst_pix", pixels, '0);
    chk("rst_wgt", weights, '0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_done", load_done, 1'b0);
    repeat (2) tick();
    rst = 0;
    repeat (10) tick();
    chk_arrays("idle");

    foreach (tbl[v]) begin
      fill(tbl[v].pf, tbl[v].wf);
      load(0);
      junk_ticks(3);
      chk("tbl_pixel", pixels[tbl[v].pr][tbl[v].pc], tbl[v].pe);
      chk("tbl_weight", weights[tbl[v].f][tbl[v].wr][tbl[v].wc], tbl[v].we);
      chk_arrays("tbl");
      state = 0;
      tick();
    end

    fill(8'h00, 8'h00);
    stream[0] = 8'h01; stream[3] = 8'h10; stream[106] = 8'h80;
    load(0);
    chk("sparse_p00", pixels[0][0], 1'b1);
    chk("sparse_p10", pixels[1][0], 1'b1);
    chk("sparse_w722", weights[7][2][2], 1'b1);
    chk("sparse_pcnt", $countones(pixels), 2);
    chk("sparse_wcnt", $countones(weights), 1);
    chk_arrays("sparse");
    state = 0; tick();

    fill(8'hAA, 8'hFF);
    load(5);
    junk_ticks(4);
    chk_arrays("gaps");
    state = 0; junk_ticks(2);

    rand_stream();
    enter();
    send_bytes(0, 50, 2);
    state = 0;
    junk_ticks(3);
    chk_arrays("abort");
    rand_stream();
    load(2);
    chk_arrays("reload");
    state = 0; tick();

    rand_stream();
    enter();
    send_bytes(0, 106, 1);
    data_in = stream[106]; data_valid = 1; state = 0;
    tick();
    data_valid = 0;
    chk("simul_done", load_done, 1'b0);
    chk_arrays("simul");
    tick();

    rand_stream();
    enter();
    send_bytes(0, 60, 1);
    #2 rst = 1;
    #1;
    chk("async_pix", pixels, '0);
    chk("async_wgt", weights, '0);
    chk("async_ready", ready, 1'b0);
    mclear();
    tick();
    rst = 0;
    state = 0;
    tick();
    rand_stream();
    load(1);
    chk_arrays("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
